// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl -- QPSK transmit frame sequencer.
// Turns a one-cycle start request into a timed burst of preamble, PRBS
// payload and guard interval, producing the per-symbol strobe, PRBS
// advance, preamble select and I/Q mute for the transmit datapath.
// Optional feature macro: TX_CTRL_CONT_EN adds the `cont` input. With it,
// a frame that finishes its guard without an abort chains straight into
// the next preamble.
module tx_frame_ctrl #(
    parameter int OS        = 4,   // samples per symbol, >= 2
    parameter int CNT_W     = 16,  // symbol counter / payload length width
    parameter int PRE_LEN   = 32,  // preamble symbols, >= 1
    parameter int GUARD_LEN = 8    // guard symbols, >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] payload_len,
`ifdef TX_CTRL_CONT_EN
    input  logic             cont,
`endif
    output logic             sym_stb,
    output logic             prbs_en,
    output logic             pre_sel,
    output logic             tx_en,
    output logic             busy,
    output logic             frame_done,
    output logic             aborted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam int PH_W = $clog2(OS);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(OS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_PAY   = 2'd2,
        S_GUARD = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             done_q,  done_d;
    logic             abt_q,   abt_d;

    logic [CNT_W-1:0] seg_last;
    logic             seg_end;
    logic             restart;

    // Chaining into a new frame is only allowed when this frame ran clean.
`ifdef TX_CTRL_CONT_EN
    assign restart = cont & ~abt_q;
`else
    assign restart = 1'b0;
`endif

    // Last symbol index of the segment currently running, and the
    // end-of-segment condition (last sample of that last symbol).
    always_comb begin
        seg_last = '0;
        case (state_q)
            S_PRE:   seg_last = PRE_LAST;
            S_PAY:   seg_last = len_q - CNT_W'(1);
            S_GUARD: seg_last = GUARD_LAST;
            default: seg_last = '0;
        endcase
        seg_end = (phase_q == PH_LAST) && (cnt_q == seg_last);
    end

    // Next-state logic: segment sequencing, abort, phase/symbol counting.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        abt_d   = abt_q;

        // Free-running phase within the symbol; symbol index bumps on wrap.
        if (state_q != S_IDLE) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort; abort is a no-op here.
                if (start) begin
                    state_d = S_PRE;
                    len_d   = payload_len;
                    abt_d   = 1'b0;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            end
            S_PRE, S_PAY: begin
                if (abort) begin
                    state_d = S_GUARD;
                    abt_d   = 1'b1;
                    phase_d = '0;
                    cnt_d   = '0;
                end else if (seg_end) begin
                    // An empty payload skips straight to the guard.
                    if (state_q == S_PRE && len_q != '0) state_d = S_PAY;
                    else                                 state_d = S_GUARD;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            end
            S_GUARD: begin
                if (seg_end) begin
                    done_d  = 1'b1;
                    phase_d = '0;
                    cnt_d   = '0;
                    if (restart) begin
                        state_d = S_PRE;
                        len_d   = payload_len;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output
    // in the same cycle.
    assign busy       = (state_q != S_IDLE);
    assign sym_stb    = busy && (phase_q == '0);
    assign prbs_en    = sym_stb && (state_q == S_PAY);
    assign pre_sel    = (state_q == S_PRE);
    assign tx_en      = (state_q == S_PRE) || (state_q == S_PAY);
    assign frame_done = done_q;
    assign aborted    = abt_q;
    assign state      = state_q;
    assign sym_cnt    = cnt_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl with OS=4, PRE_LEN=4, GUARD_LEN=2.
// Cycle k of a frame is the k-th cycle after the edge that sampled start.
module tb_tx_frame_ctrl;

    localparam int OS = 4, CNT_W = 16, PRE_LEN = 4, GUARD_LEN = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] payload_len = '0;
`ifdef TX_CTRL_CONT_EN
    logic             cont = 1'b0;
`endif
    logic             sym_stb, prbs_en, pre_sel, tx_en, busy, frame_done, aborted;
    logic [1:0]       state;
    logic [CNT_W-1:0] sym_cnt;

    tx_frame_ctrl #(.OS(OS), .CNT_W(CNT_W), .PRE_LEN(PRE_LEN), .GUARD_LEN(GUARD_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .payload_len(payload_len),
`ifdef TX_CTRL_CONT_EN
        .cont(cont),
`endif
        .sym_stb(sym_stb), .prbs_en(prbs_en), .pre_sel(pre_sel), .tx_en(tx_en),
        .busy(busy), .frame_done(frame_done), .aborted(aborted), .state(state),
        .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int prbs_n, done_n, done_at, txfall, idle_at;
    int prbs_at [8];
    int saved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] all_out();
        return 32'({sym_stb, prbs_en, pre_sel, tx_en, busy, frame_done, aborted, state, sym_cnt});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe cycles first..last of the current frame (already sitting in
    // cycle `first`), recording event cycles; ends sitting in cycle `last`.
    task automatic watch(input int first, input int last);
        prbs_n = 0; done_n = 0; done_at = -1; txfall = -1; idle_at = -1;
        for (int k = first; k <= last; k++) begin
            if (prbs_en) begin
                if (prbs_n < 8) prbs_at[prbs_n] = k;
                prbs_n++;
            end
            if (frame_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (!tx_en && txfall < 0) txfall = k;
            if (!busy && idle_at < 0) idle_at = k;
            if (k < last) step();
        end
    endtask

    initial begin
        // Reset held for 10 cycles, then released
        repeat (10) step();
        chk("reset_outputs", all_out(), 0);
        reset = 1'b1;
        step();
        chk("post_reset_outputs", all_out(), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_state", 32'(state), 0);
        chk("idle_abort_flag", 32'(aborted), 0);

        // Nominal frame, N=3; later payload_len changes must be ignored
        payload_len = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        payload_len = 7;
        chk("nom_k1_flags", 32'({busy, pre_sel, tx_en, sym_stb, prbs_en}), 32'b11110);
        chk("nom_k1_state", 32'(state), 1);
        watch(1, 16);
        chk("nom_pre_prbs", 32'(prbs_n), 0);
        chk("nom_k16_symcnt", 32'(sym_cnt), 3);
        chk("nom_k16_stb", 32'(sym_stb), 0);
        step();
        chk("nom_k17_state", 32'(state), 2);
        chk("nom_k17_symcnt", 32'(sym_cnt), 0);
        chk("nom_k17_presel", 32'(pre_sel), 0);
        watch(17, 37);
        chk("nom_prbs_n", 32'(prbs_n), 3);
        chk("nom_prbs0", 32'(prbs_at[0]), 17);
        chk("nom_prbs1", 32'(prbs_at[1]), 21);
        chk("nom_prbs2", 32'(prbs_at[2]), 25);
        chk("nom_done_n", 32'(done_n), 1);
        chk("nom_done_at", 32'(done_at), 37);
        chk("nom_txfall", 32'(txfall), 29);
        chk("nom_idle_at", 32'(idle_at), 37);
        chk("nom_done_state", 32'(state), 0);

        // Empty payload, started in the frame_done cycle with abort also high
        payload_len = 0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("emp_k1_state", 32'(state), 1);
        chk("emp_k1_aborted", 32'(aborted), 0);
        watch(1, 19);
        chk("emp_txfall", 32'(txfall), 17);
        saved = prbs_n;
        chk("emp_k19_state", 32'(state), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("emp_guard_abort_state", 32'(state), 3);
        watch(20, 30);
        chk("emp_prbs_n", 32'(saved + prbs_n), 0);
        chk("emp_done_at", 32'(done_at), 25);
        chk("emp_aborted", 32'(aborted), 0);

        // Abort during payload, N=5
        payload_len = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        watch(1, 19);
        chk("abt_prbs_n_pre", 32'(prbs_n), 1);
        chk("abt_prbs0", 32'(prbs_at[0]), 17);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt_k20_state", 32'(state), 3);
        chk("abt_k20_flag", 32'(aborted), 1);
        chk("abt_k20_seg", 32'({tx_en, sym_stb, sym_cnt}), 32'h1_0000);
        watch(20, 28);
        chk("abt_prbs_n_post", 32'(prbs_n), 0);
        chk("abt_done_at", 32'(done_at), 28);
        chk("abt_k28_idle", 32'({state, busy}), 0);
        chk("abt_k28_flag", 32'(aborted), 1);

        // Start pulsed while busy is ignored
        payload_len = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_k1_aborted", 32'(aborted), 0);
        watch(1, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_k11_state", 32'(state), 1);
        watch(11, 37);
        chk("ign_prbs_n", 32'(prbs_n), 3);
        chk("ign_prbs0", 32'(prbs_at[0]), 17);
        chk("ign_done_at", 32'(done_at), 37);

        // Asynchronous reset during preamble
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("rst_mid_busy", 32'({busy, pre_sel}), 32'b11);
        #2 reset = 1'b0;
        #1 chk("rst_mid_async", all_out(), 0);
        saved = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (all_out() != 0) saved++;
        end
        chk("rst_mid_held", 32'(saved), 0);
        reset = 1'b1;
        step();
        chk("rst_mid_release", all_out(), 0);

`ifdef TX_CTRL_CONT_EN
        // Continuous mode, N=1: back-to-back frames
        payload_len = 1;
        cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        watch(1, 60);
        chk("cont_done_n", 32'(done_n), 2);
        chk("cont_done_at", 32'(done_at), 29);
        chk("cont_idle_at", 32'(idle_at), 32'(-1));
        chk("cont_prbs_n", 32'(prbs_n), 2);
        chk("cont_prbs1", 32'(prbs_at[1]), 45);
        cont = 1'b0;
        watch(61, 85);
        chk("cont_last_done", 32'(done_at), 85);
        chk("cont_last_idle", 32'(idle_at), 85);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
